// File: rtl/wimax_pkg.sv
// Shared WiMAX TX-chain definitions: block size, QPSK amplitude,
// I/Q sample type and the QPSK mapper read-state encoding.
package wimax_pkg;

    localparam int NCBPS_QPSK = 192;
    localparam int QPSK_IQW = 16;

    localparam logic signed [QPSK_IQW-1:0] QPSK_AMP = 16'sd23170;

    typedef logic signed [QPSK_IQW-1:0] iq_t;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } qpsk_rd_state_t;

endpackage

// File: rtl/pingpong_bitbuf.sv
// Two-bank bit buffer: 1-bit indexed write side, 2-bit symbol read
// side, per-bank full flags and the write/read bank pointers.
module pingpong_bitbuf
    import wimax_pkg::*;
#(
    parameter int NCBPS = NCBPS_QPSK,
    localparam int AW = $clog2(NCBPS),
    localparam int SW = $clog2(NCBPS / 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_bit,
    input  logic [AW-1:0] wr_idx,
    output logic          wr_ready,
    input  logic          rd_other,
    input  logic [SW-1:0] rd_sym,
    output logic [1:0]    rd_bits,
    input  logic          rd_release,
    output logic          full_cur,
    output logic          full_nxt
);

    localparam logic [AW-1:0] LAST_BIT = AW'(NCBPS - 1);
    localparam logic [AW:0] NC = (AW + 1)'(NCBPS);

    logic [NCBPS-1:0] mem [2];
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [AW-1:0]    wr_cnt;
    logic             accept;
    logic             wr_done;
    logic             in_range;
    logic             rd_b;

    assign wr_ready = !full[wr_bank];
    assign accept   = wr_en && wr_ready;
    assign wr_done  = accept && (wr_cnt == LAST_BIT);
    assign in_range = {1'b0, wr_idx} < NC;

    assign rd_b     = rd_bank ^ rd_other;
    assign rd_bits  = mem[rd_b][{rd_sym, 1'b0} +: 2];
    assign full_cur = full[rd_bank];
    assign full_nxt = full[~rd_bank];

    // Storage is intentionally not reset; a stale bank is simply rewritten.
    always_ff @(posedge clk) begin
        if (!reset && accept && in_range) begin
            mem[wr_bank][wr_idx] <= wr_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            if (accept) begin
                if (wr_done) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (wr_done) begin
                full[wr_bank] <= 1'b1;
            end
            if (rd_release) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

endmodule

// File: rtl/qpsk_mapper.sv
// Reassembles interleaved blocks and maps them to Gray QPSK I/Q symbols.
// Define QPSK_IDX_CHECK_EN to add the sticky idx_err output.
module qpsk_mapper
    import wimax_pkg::*;
#(
    parameter int NCBPS = NCBPS_QPSK,
    parameter int IQW = QPSK_IQW,
    parameter logic signed [IQW-1:0] AMP = QPSK_AMP,
    localparam int AW = $clog2(NCBPS),
    localparam int SW = $clog2(NCBPS / 2)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  data_in,
    input  logic [AW-1:0]         data_in_index,
    output logic                  ready_mod,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic signed [IQW-1:0] i_out,
    output logic signed [IQW-1:0] q_out,
    output logic [SW-1:0]         sym_index
`ifdef QPSK_IDX_CHECK_EN
   ,output logic                  idx_err
`endif
);

    localparam logic [SW-1:0] LAST_SYM = SW'(NCBPS / 2 - 1);

    qpsk_rd_state_t        state;
    logic                  xfer;
    logic                  last_sym;
    logic                  rd_other;
    logic                  rd_release;
    logic [SW-1:0]         rd_sym;
    logic [1:0]            rd_bits;
    logic                  full_cur;
    logic                  full_nxt;
    logic signed [IQW-1:0] i_nxt;
    logic signed [IQW-1:0] q_nxt;

    pingpong_bitbuf #(
        .NCBPS(NCBPS)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (valid_in),
        .wr_bit    (data_in),
        .wr_idx    (data_in_index),
        .wr_ready  (ready_mod),
        .rd_other  (rd_other),
        .rd_sym    (rd_sym),
        .rd_bits   (rd_bits),
        .rd_release(rd_release),
        .full_cur  (full_cur),
        .full_nxt  (full_nxt)
    );

    assign xfer     = valid_out && ready_in;
    assign last_sym = (sym_index == LAST_SYM);
    assign i_nxt    = rd_bits[0] ? -AMP : AMP;
    assign q_nxt    = rd_bits[1] ? -AMP : AMP;

    // On the final transfer, prefetch symbol 0 of the other bank so
    // back-to-back blocks stream without a bubble.
    always_comb begin
        rd_other   = 1'b0;
        rd_release = 1'b0;
        rd_sym     = '0;
        if (state == RD_STREAM && valid_out) begin
            if (xfer && last_sym) begin
                rd_other   = 1'b1;
                rd_release = 1'b1;
            end else if (!last_sym) begin
                rd_sym = sym_index + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RD_IDLE;
            valid_out <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            sym_index <= '0;
        end else begin
            case (state)
                RD_IDLE: begin
                    if (full_cur) begin
                        state <= RD_STREAM;
                    end
                end
                RD_STREAM: begin
                    if (!valid_out) begin
                        valid_out <= 1'b1;
                        i_out     <= i_nxt;
                        q_out     <= q_nxt;
                        sym_index <= '0;
                    end else if (xfer) begin
                        if (!last_sym) begin
                            i_out     <= i_nxt;
                            q_out     <= q_nxt;
                            sym_index <= sym_index + 1'b1;
                        end else if (full_nxt) begin
                            i_out     <= i_nxt;
                            q_out     <= q_nxt;
                            sym_index <= '0;
                        end else begin
                            valid_out <= 1'b0;
                            state     <= RD_IDLE;
                        end
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

`ifdef QPSK_IDX_CHECK_EN
    localparam logic [AW:0] NC = (AW + 1)'(NCBPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_err <= 1'b0;
        end else if (valid_in && ready_mod
                     && ({1'b0, data_in_index} >= NC)) begin
            idx_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_qpsk_mapper.sv
// Self-checking bench for qpsk_mapper: directed block scenarios with
// random data, checked against a block-level reference model.
module tb_qpsk_mapper;

    localparam int N  = 192;
    localparam int NS = 96;
    localparam logic signed [15:0] A = 16'sd23170;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               valid_in = 1'b0;
    logic               data_in = 1'b0;
    logic [7:0]         data_in_index = '0;
    logic               ready_mod;
    logic               valid_out;
    logic               ready_in = 1'b0;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic [6:0]         sym_index;
`ifdef QPSK_IDX_CHECK_EN
    logic               idx_err;
`endif

    qpsk_mapper dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .data_in_index(data_in_index),
        .ready_mod    (ready_mod),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .i_out        (i_out),
        .q_out        (q_out),
        .sym_index    (sym_index)
`ifdef QPSK_IDX_CHECK_EN
       ,.idx_err      (idx_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
        logic [6:0]         s;
    } sym_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_got = 0;
    int   n_push = 0;
    int   rmode = 1;
    bit   chk_en = 1'b0;
    sym_t expq[$];
    bit   mdl[2][N];
    int   mbank = 0;
    int   mcnt = 0;
    logic [7:0] pidx[N];
    bit   pval[N];

    // Downstream ready: 0 = stalled, 1 = always ready, 2 = random 50%
    always @(posedge clk) begin
        #1;
        if (rmode == 0) ready_in = 1'b0;
        else if (rmode == 1) ready_in = 1'b1;
        else ready_in = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_block(input int b);
        sym_t e;
        for (int n = 0; n < NS; n++) begin
            e.i = mdl[b][2*n]   ? -A : A;
            e.q = mdl[b][2*n+1] ? -A : A;
            e.s = 7'(n);
            expq.push_back(e);
            n_push++;
        end
    endtask

    task automatic send_bit(input bit b, input logic [7:0] idx);
        int g = 0;
        @(negedge clk);
        valid_in = 1'b1;
        data_in = b;
        data_in_index = idx;
        while (!ready_mod && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (!ready_mod) begin
            n_vec++;
            n_err++;
            $error("FAIL wr_timeout got ready_mod=0 exp 1");
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        if (idx < N) mdl[mbank][idx] = b;
        mcnt++;
        if (mcnt == N) begin
            push_block(mbank);
            mbank ^= 1;
            mcnt = 0;
        end
        #1 valid_in = 1'b0;
    endtask

    task automatic send_block();
        for (int k = 0; k < N; k++) send_bit(pval[k], pidx[k]);
    endtask

    task automatic rand_perm_block();
        int j;
        logic [7:0] t;
        for (int k = 0; k < N; k++) begin
            pidx[k] = 8'(k);
            pval[k] = 1'($urandom_range(0, 1));
        end
        for (int k = N - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = pidx[k];
            pidx[k] = pidx[j];
            pidx[j] = t;
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((expq.size() != 0 || valid_out) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("drain", {63'd0, expq.size() == 0 && !valid_out}, 64'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready_mod"}, {63'd0, ready_mod}, 64'd1);
        chk({tag, "_valid_out"}, {63'd0, valid_out}, 64'd0);
        chk({tag, "_iq"}, {32'd0, i_out, q_out}, 64'd0);
        chk({tag, "_sym"}, {57'd0, sym_index}, 64'd0);
    endtask

    logic               stl = 1'b0;
    logic signed [15:0] pi, pq;
    logic [6:0]         ps;

    always @(negedge clk) begin
        sym_t e;
        if (chk_en && !reset) begin
            if (stl) begin
                n_vec++;
                assert (valid_out === 1'b1 && i_out === pi
                        && q_out === pq && sym_index === ps) else begin
                    n_err++;
                    $error("FAIL stall_hold got v=%b i=%0d q=%0d s=%0d exp i=%0d q=%0d s=%0d",
                           valid_out, i_out, q_out, sym_index, pi, pq, ps);
                end
            end
            if (valid_out === 1'b1 && ready_in === 1'b1) begin
                n_got++;
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $error("FAIL extra_sym got s=%0d exp none", sym_index);
                end else begin
                    e = expq.pop_front();
                    assert ({i_out, q_out, sym_index} === e) else begin
                        n_err++;
                        $error("FAIL symbol got i=%0d q=%0d s=%0d exp i=%0d q=%0d s=%0d",
                               i_out, q_out, sym_index, e.i, e.q, e.s);
                    end
                end
            end
            stl = (valid_out === 1'b1) && (ready_in === 1'b0);
            pi = i_out;
            pq = q_out;
            ps = sym_index;
        end else begin
            stl = 1'b0;
        end
    end

    initial begin
        #2000000;
        $error("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;
        chk_en = 1'b1;

        // 1) identity index, alternating bits, latency
        rmode = 1;
        for (int k = 0; k < N; k++) begin
            pidx[k] = 8'(k);
            pval[k] = k[0];
        end
        send_block();
        @(posedge clk);
        #1 chk("lat_e1_valid", {63'd0, valid_out}, 64'd0);
        @(posedge clk);
        #1 chk("lat_e2_valid", {63'd0, valid_out}, 64'd1);
        chk("lat_e2_sym0", {25'd0, i_out, q_out, sym_index},
            {25'd0, A, -A, 7'd0});
        wait_drain();

        // 2) reverse index, bit = index LSB
        for (int k = 0; k < N; k++) begin
            pidx[k] = 8'(N - 1 - k);
            pval[k] = pidx[k][0];
        end
        send_block();
        wait_drain();

        // 3) three blocks with downstream stalled
        rmode = 0;
        @(negedge clk);
        g0 = n_got;
        rand_perm_block();
        send_block();
        rand_perm_block();
        send_block();
        @(negedge clk);
        chk("t3_ready_low", {63'd0, ready_mod}, 64'd0);
        chk("t3_held_sym0", {56'd0, valid_out, sym_index}, {56'd0, 1'b1, 7'd0});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t3_ready_hold", {63'd0, ready_mod}, 64'd0);
        end
        rmode = 1;
        rand_perm_block();
        send_block();
        wait_drain();
        chk("t3_count", 64'(n_got - g0), 64'd288);

        // 4) random downstream backpressure
        rmode = 2;
        for (int b = 0; b < 3; b++) begin
            rand_perm_block();
            send_block();
        end
        wait_drain();

        // 5) reset mid-block then one full block
        rmode = 1;
        rand_perm_block();
        for (int k = 0; k < 100; k++) send_bit(pval[k], pidx[k]);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_state("mid_rst");
        mcnt = 0;
        mbank = 0;
        reset = 1'b0;
        g0 = n_got;
        rand_perm_block();
        send_block();
        wait_drain();
        chk("t5_count", 64'(n_got - g0), 64'd96);

        // 6) out-of-range index dropped, counter still advances
`ifdef QPSK_IDX_CHECK_EN
        chk("idx_err_pre", {63'd0, idx_err}, 64'd0);
`endif
        rand_perm_block();
        for (int k = 0; k < N; k++) begin
            if (pidx[k] == 8'd5) pidx[k] = 8'd200;
        end
        send_block();
        wait_drain();
`ifdef QPSK_IDX_CHECK_EN
        chk("idx_err_set", {63'd0, idx_err}, 64'd1);
`endif
        rand_perm_block();
        send_block();
        wait_drain();
`ifdef QPSK_IDX_CHECK_EN
        chk("idx_err_sticky", {63'd0, idx_err}, 64'd1);
`endif

        chk("total_syms", 64'(n_got), 64'(n_push));
        chk("queue_empty", 64'(expq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
